regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the RV64 pipeline with N read ports, one write port,
//  same-cycle write->read bypass, hardwired-zero x0 and an integrated busy-bit scoreboard.
//  Decode reads operands and marks the destination pending at issue; writeback clears it.
//  Sits between decode/issue and writeback; replaces the fixed 2-read, reset-less register file.
// PARAMETERS
//  DATA_W    64  width of each register
//  NUM_REGS  32  number of architectural registers (power of 2, >=2)
//  NUM_RD    2   number of read ports (1..4)
//  ADDR_W    $clog2(NUM_REGS)  derived; not overridden
// PORTS
//  clk          in   1                  clock; all state updates on posedge
//  reset        in   1                  asynchronous, active-high; clears all state
//  rd_reg       in   NUM_RD x ADDR_W    read-port register indices
//  rd_data      out  NUM_RD x DATA_W    read data, combinational
//  rd_busy      out  NUM_RD             source register has an outstanding producer
//  wr_en        in   1                  writeback valid
//  wr_reg       in   ADDR_W             writeback destination
//  wr_data      in   DATA_W             writeback data
//  issue_en     in   1                  instruction issued with a destination register
//  issue_reg    in   ADDR_W             destination being marked pending
//  flush        in   1                  pipeline flush: drop all pending marks
//  pending_cnt  out  ADDR_W+1           number of busy registers
// BEHAVIOUR
//  - Clocking: one clock (clk); reset asynchronous, active-high. While reset is high, all
//    registers = 0, all busy bits = 0 and pending_cnt = 0. Hence rd_data = 0 and rd_busy = 0.
//  - Register 0: reads return 0; rd_busy = 0. Writes and issues to index 0 are ignored.
//    Index 0 never counts toward pending_cnt.
//  - Write: at posedge, if wr_en && wr_reg != 0, then regs[wr_reg] <= wr_data. Write latency is 1 cycle.
//  - Read (per port p, combinational, zero latency):
//    - rd_reg[p] == 0 -> rd_data[p] = 0.
//    - else if wr_en && wr_reg == rd_reg[p] -> rd_data[p] = wr_data (bypass).
//    - else rd_data[p] = regs[rd_reg[p]].
//  - rd_busy[p] = busy[rd_reg[p]] && !(wr_en && wr_reg == rd_reg[p]).
//    A same-cycle writeback resolves the hazard.
//  - Busy update at posedge, in priority order:
//    1. flush -> all busy <= 0. A same-cycle issue is discarded. A same-cycle write still updates regs.
//    2. issue_en && wr_en && issue_reg == wr_reg != 0 -> busy stays 1 (new producer wins over clear).
//    3. Otherwise issue sets busy[issue_reg] and write clears busy[wr_reg].
//  - Re-issue to an already-busy register leaves its busy bit at 1; pending_cnt is unchanged.
//  - A write to a non-busy register is legal: data is written, busy stays 0, pending_cnt is unchanged.
//  - pending_cnt is a registered counter equal to popcount(busy[NUM_REGS-1:1]) at all times:
//    - +1 on a 0->1 transition; -1 on a 1->0 transition.
//    - Net 0 when one bit sets and another clears in the same cycle.
//    - Set to 0 on flush.
//    - Never wraps: its maximum is NUM_REGS-1, which fits in ADDR_W+1 bits.
//  - Reset asserted mid-operation clears regs, busy and count immediately. The first write or
//    issue is accepted on the first posedge after deassertion.
//  - Out-of-range indices cannot occur because NUM_REGS is a power of 2.
// STRUCTURE
//  - Package regfile_pkg: DATA_W/NUM_REGS defaults, typedef reg_idx_t (logic [ADDR_W-1:0]),
//    typedef reg_data_t (logic [DATA_W-1:0]), localparam ZERO_REG = '0.
//  - Sub-module regfile_busy_table: the busy-bit vector, set/clear/flush priority and pending_cnt.
//    Exposes busy[NUM_REGS-1:0].
//  - Top level: data array, write logic, read ports with bypass (generate loop over NUM_RD),
//    and rd_busy masking.
//  - Assertion: pending_cnt == $countones(busy).
// TESTING
//  1. Reset then read all 32 regs on both ports -> rd_data = 0, rd_busy = 0, pending_cnt = 0.
//  2. Write x5 = 0xDEAD_BEEF_0000_0001 while reading x5 in the same cycle -> rd_data = bypass value.
//     Next cycle with wr_en = 0 -> same value read from the array.
//  3. Write x0 = 0xFFFF_FFFF_FFFF_FFFF and issue x0 -> x0 reads 0, rd_busy = 0, pending_cnt = 0.
//  4. Issue x3, x7 and x9 on consecutive cycles -> pending_cnt = 3 and rd_busy set for each.
//     Then write x7 together with issue x7 -> busy[7] stays 1 and pending_cnt = 3.
//     Then write x3 -> pending_cnt = 2.
//  5. With x4 and x6 busy, assert flush together with issue x8 and write x4 = 0x42 ->
//     all busy = 0, pending_cnt = 0, x4 reads 0x42.
//  6. Assert reset asynchronously mid-cycle with pending_cnt = 2 and x10 = 0x55 ->
//     outputs clear before the next edge. After release, issue x10 -> pending_cnt = 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, index/data types and the hardwired-zero register index
package regfile_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF = $clog2(NUM_REGS_DEF);
  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_busy_table.sv
// regfile_busy_table: per-register busy bits with flush/issue/writeback priority and a pending counter
// Ports: clk, reset (async, active-high); issue_en_i/issue_reg_i mark a destination pending;
// wr_en_i/wr_reg_i clear it on writeback; flush_i drops all marks;
// busy_o is the busy vector; pending_cnt_o is the number of busy registers.
module regfile_busy_table import regfile_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_en_i,
  input  logic [ADDR_W-1:0]   issue_reg_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_reg_i,
  input  logic                flush_i,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [ADDR_W:0]     pending_cnt_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d, set_v, clr_v;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic iss, wr, inc, dec;
  always_comb begin
    iss = issue_en_i && issue_reg_i != ADDR_W'(ZERO_REG);
    wr = wr_en_i && wr_reg_i != ADDR_W'(ZERO_REG);
    set_v = iss ? NUM_REGS'(1) << issue_reg_i : '0;
    clr_v = wr ? NUM_REGS'(1) << wr_reg_i : '0;
    // set is applied after clear so a same-register issue keeps the bit high
    busy_d = flush_i ? '0 : (busy_q & ~clr_v) | set_v;
    inc = iss && !busy_q[issue_reg_i];
    dec = wr && busy_q[wr_reg_i] && !(iss && issue_reg_i == wr_reg_i);
    cnt_d = flush_i ? '0 : cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (cnt_q == (ADDR_W+1)'($countones(busy_q)));
  end
  assign busy_o = busy_q;
  assign pending_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: N-read/1-write register file with write->read bypass, zero x0 and busy scoreboard
// Ports: clk, reset (async, active-high); rd_reg_i/rd_data_o/rd_busy_o are NUM_RD packed read ports;
// wr_en_i/wr_reg_i/wr_data_i writeback; issue_en_i/issue_reg_i mark pending; flush_i drops marks;
// pending_cnt_o counts busy registers.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_reg_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_reg_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_reg_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          pending_cnt_o
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  regfile_busy_table #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_busy (
    .clk(clk),
    .reset(reset),
    .issue_en_i(issue_en_i),
    .issue_reg_i(issue_reg_i),
    .wr_en_i(wr_en_i),
    .wr_reg_i(wr_reg_i),
    .flush_i(flush_i),
    .busy_o(busy),
    .pending_cnt_o(pending_cnt_o)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '{default: '0};
    else if (wr_en_i && wr_reg_i != ADDR_W'(ZERO_REG)) regs_q[wr_reg_i] <= wr_data_i;
  end
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic hit;
    assign a = rd_reg_i[p*ADDR_W +: ADDR_W];
    assign hit = wr_en_i && wr_reg_i == a;
    assign rd_data_o[p*DATA_W +: DATA_W] = a == ADDR_W'(ZERO_REG) ? '0 : hit ? wr_data_i : regs_q[a];
    // busy[0] is never set, so x0 needs no extra masking here
    assign rd_busy_o[p] = busy[a] && !hit;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, bypass, x0, scoreboard priority, flush and async reset
module tb_regfile_scoreboard;
  logic clk = 0;
  logic reset = 1;
  logic [9:0] rd_reg = '0;
  logic [127:0] rd_data;
  logic [1:0] rd_busy;
  logic wr_en = 0, issue_en = 0, flush = 0;
  logic [4:0] wr_reg = '0, issue_reg = '0;
  logic [63:0] wr_data = '0;
  logic [5:0] pending_cnt;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  regfile_scoreboard dut (
    .clk(clk),
    .reset(reset),
    .rd_reg_i(rd_reg),
    .rd_data_o(rd_data),
    .rd_busy_o(rd_busy),
    .wr_en_i(wr_en),
    .wr_reg_i(wr_reg),
    .wr_data_i(wr_data),
    .issue_en_i(issue_en),
    .issue_reg_i(issue_reg),
    .flush_i(flush),
    .pending_cnt_o(pending_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_reg = {a1, a0};
    #1;
  endtask
  task automatic idle;
    wr_en = 0;
    issue_en = 0;
    flush = 0;
  endtask
  initial begin
    #2;
    chk("reset_cnt", 64'(pending_cnt), 0);
    repeat (2) tick;
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk("init_rd0", rd_data[63:0], 0);
      chk("init_rd1", rd_data[127:64], 0);
      chk("init_busy", 64'(rd_busy), 0);
    end
    chk("init_cnt", 64'(pending_cnt), 0);
    wr_en = 1; wr_reg = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
    rd(5, 0);
    chk("bypass_x5", rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("bypass_x0", rd_data[127:64], 0);
    tick;
    idle;
    rd(0, 5);
    chk("array_x5", rd_data[127:64], 64'hDEAD_BEEF_0000_0001);
    wr_en = 1; wr_reg = 0; wr_data = '1; issue_en = 1; issue_reg = 0;
    rd(0, 0);
    chk("x0_bypass", rd_data[63:0], 0);
    chk("x0_busy_same", 64'(rd_busy), 0);
    tick;
    idle;
    rd(0, 0);
    chk("x0_after", rd_data[127:64], 0);
    chk("x0_busy", 64'(rd_busy), 0);
    chk("x0_cnt", 64'(pending_cnt), 0);
    issue_en = 1; issue_reg = 3; tick;
    issue_reg = 7; tick;
    issue_reg = 9; tick;
    idle;
    chk("iss3_cnt", 64'(pending_cnt), 3);
    rd(3, 7);
    chk("iss_busy37", 64'(rd_busy), 3);
    rd(9, 1);
    chk("iss_busy9", 64'(rd_busy), 1);
    wr_en = 1; wr_reg = 7; wr_data = 64'h77; issue_en = 1; issue_reg = 7;
    rd(3, 7);
    chk("wr7_hit_busy", 64'(rd_busy), 1);
    chk("wr7_bypass", rd_data[127:64], 64'h77);
    tick;
    idle;
    rd(3, 7);
    chk("reiss7_busy", 64'(rd_busy), 3);
    chk("reiss7_cnt", 64'(pending_cnt), 3);
    chk("x7_data", rd_data[127:64], 64'h77);
    issue_en = 1; issue_reg = 9; tick;
    idle;
    chk("reiss9_cnt", 64'(pending_cnt), 3);
    wr_en = 1; wr_reg = 3; wr_data = 64'h33; tick;
    idle;
    rd(3, 7);
    chk("wr3_cnt", 64'(pending_cnt), 2);
    chk("wr3_busy", 64'(rd_busy), 2);
    wr_en = 1; wr_reg = 12; wr_data = 64'h12; tick;
    idle;
    chk("wr_nonbusy_cnt", 64'(pending_cnt), 2);
    issue_en = 1; issue_reg = 4; tick;
    issue_reg = 6; tick;
    idle;
    chk("pre_flush_cnt", 64'(pending_cnt), 4);
    flush = 1; issue_en = 1; issue_reg = 8; wr_en = 1; wr_reg = 4; wr_data = 64'h42;
    tick;
    idle;
    rd(4, 6);
    chk("flush_cnt", 64'(pending_cnt), 0);
    chk("flush_busy46", 64'(rd_busy), 0);
    chk("flush_x4", rd_data[63:0], 64'h42);
    rd(8, 7);
    chk("flush_busy87", 64'(rd_busy), 0);
    wr_en = 1; wr_reg = 10; wr_data = 64'h55; tick;
    idle;
    issue_en = 1; issue_reg = 12; tick;
    issue_reg = 13; tick;
    idle;
    rd(10, 12);
    chk("pre_rst_cnt", 64'(pending_cnt), 2);
    chk("pre_rst_x10", rd_data[63:0], 64'h55);
    chk("pre_rst_busy", 64'(rd_busy), 2);
    #2 reset = 1;
    #1;
    chk("rst_cnt", 64'(pending_cnt), 0);
    chk("rst_x10", rd_data[63:0], 0);
    chk("rst_busy", 64'(rd_busy), 0);
    tick;
    #2 reset = 0;
    issue_en = 1; issue_reg = 10; tick;
    idle;
    rd(10, 0);
    chk("post_rst_cnt", 64'(pending_cnt), 1);
    chk("post_rst_busy", 64'(rd_busy), 1);
    chk("post_rst_x10", rd_data[63:0], 0);
    issue_en = 1; issue_reg = 14; wr_en = 1; wr_reg = 10; wr_data = 64'hA;
    tick;
    idle;
    rd(10, 14);
    chk("swap_cnt", 64'(pending_cnt), 1);
    chk("swap_busy", 64'(rd_busy), 2);
    chk("swap_x10", rd_data[63:0], 64'hA);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
